// File: rtl/parity_stream.sv
// rtl/parity_stream.sv - Streaming packet parity generator/checker with one-entry result buffer.
module parity_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_odd,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_par,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_parity,
    output logic              m_error,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t             state_q;
    logic               acc_q;
    logic               mode_q;
    logic               busy_q;
    logic               m_valid_q;
    logic               m_parity_q;
    logic               m_error_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   pkt_cnt_q;

    logic               beat_par;
    logic               s_accept;
    logic               m_consume;
    logic               eff_mode;
    logic               par_d;
    logic               err_d;

    // A single-beat packet has no latched mode yet, so it uses the live input.
    assign beat_par  = ^s_data;
    assign s_ready   = !m_valid_q || m_ready;
    assign s_accept  = s_valid && s_ready;
    assign m_consume = m_valid_q && m_ready;
    assign eff_mode  = (state_q == IDLE) ? mode_odd : mode_q;
    assign par_d     = acc_q ^ beat_par ^ eff_mode;
    assign err_d     = (par_d != s_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_parity_q <= 1'b0;
            m_error_q  <= 1'b0;
            err_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (m_consume) begin
                m_valid_q <= 1'b0;
            end
            if (s_accept) begin
                if (state_q == IDLE) begin
                    mode_q <= mode_odd;
                end
                if (s_last) begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    acc_q      <= 1'b0;
                    m_valid_q  <= 1'b1;
                    m_parity_q <= par_d;
                    m_error_q  <= err_d;
                    pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
                    if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_q <= ACC;
                    busy_q  <= 1'b1;
                    acc_q   <= acc_q ^ beat_par;
                end
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_parity = m_parity_q;
    assign m_error  = m_error_q;
    assign err_cnt  = err_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_parity_stream.sv
// tb/tb_parity_stream.sv - Scoreboard bench for parity_stream at DATA_W 32, 1 and 256.
module tb_parity_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode_odd;
    logic         s_valid;
    logic [255:0] d256;
    logic         s_last;
    logic         s_par;
    logic         m_ready;

    logic         s_ready32, m_valid32, m_parity32, m_error32, busy32;
    logic [1:0]   err_cnt32, pkt_cnt32;
    logic         s_ready1, m_valid1, m_parity1, m_error1, busy1;
    logic [3:0]   err_cnt1, pkt_cnt1;
    logic         s_ready256, m_valid256, m_parity256, m_error256, busy256;
    logic [3:0]   err_cnt256, pkt_cnt256;

    always #5 clk = ~clk;

    parity_stream #(.DATA_W(32), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode_odd), .s_valid(s_valid), .s_ready(s_ready32),
        .s_data(d256[31:0]), .s_last(s_last), .s_par(s_par), .m_valid(m_valid32), .m_ready(m_ready),
        .m_parity(m_parity32), .m_error(m_error32), .err_cnt(err_cnt32), .pkt_cnt(pkt_cnt32), .busy(busy32));

    parity_stream #(.DATA_W(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode_odd), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(d256[0:0]), .s_last(s_last), .s_par(s_par), .m_valid(m_valid1), .m_ready(m_ready),
        .m_parity(m_parity1), .m_error(m_error1), .err_cnt(err_cnt1), .pkt_cnt(pkt_cnt1), .busy(busy1));

    parity_stream #(.DATA_W(256), .CNT_W(4)) u256 (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode_odd), .s_valid(s_valid), .s_ready(s_ready256),
        .s_data(d256), .s_last(s_last), .s_par(s_par), .m_valid(m_valid256), .m_ready(m_ready),
        .m_parity(m_parity256), .m_error(m_error256), .err_cnt(err_cnt256), .pkt_cnt(pkt_cnt256), .busy(busy256));

    typedef struct {
        logic par32, err32, par1, err1, par256, err256;
    } result_t;

    result_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    // Reference model state
    logic    in_pkt, m_mode, acc32, acc1, acc256;
    int      pkt_n, err32_n, err1_n, err256_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic model_reset();
        in_pkt = 0; m_mode = 0; acc32 = 0; acc1 = 0; acc256 = 0;
        pkt_n = 0; err32_n = 0; err1_n = 0; err256_n = 0;
        exp_q.delete();
    endtask

    task automatic model_beat();
        logic    bp32, bp1, bp256;
        result_t r;
        bp32 = ^d256[31:0]; bp1 = d256[0]; bp256 = ^d256;
        if (!in_pkt) m_mode = mode_odd;
        if (!s_last) begin
            acc32 ^= bp32; acc1 ^= bp1; acc256 ^= bp256; in_pkt = 1;
        end else begin
            r.par32  = acc32 ^ bp32 ^ m_mode;   r.err32  = r.par32  != s_par;
            r.par1   = acc1 ^ bp1 ^ m_mode;     r.err1   = r.par1   != s_par;
            r.par256 = acc256 ^ bp256 ^ m_mode; r.err256 = r.par256 != s_par;
            exp_q.push_back(r);
            pkt_n++;
            err32_n += r.err32; err1_n += r.err1; err256_n += r.err256;
            acc32 = 0; acc1 = 0; acc256 = 0; in_pkt = 0;
        end
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic step(output logic accepted);
        logic cons;
        logic exp_rdy;
        @(negedge clk);
        exp_rdy  = (exp_q.size() == 0) || m_ready;
        accepted = s_valid && exp_rdy;
        cons     = (exp_q.size() != 0) && m_ready;
        check("s_ready32", s_ready32, exp_rdy);
        check("s_ready1", s_ready1, exp_rdy);
        check("s_ready256", s_ready256, exp_rdy);
        check("m_valid32", m_valid32, exp_q.size() != 0);
        check("m_valid256", m_valid256, exp_q.size() != 0);
        check("busy32", busy32, in_pkt);
        if (exp_q.size() != 0) begin
            check("m_parity32", m_parity32, exp_q[0].par32);
            check("m_error32", m_error32, exp_q[0].err32);
            check("m_parity1", m_parity1, exp_q[0].par1);
            check("m_error1", m_error1, exp_q[0].err1);
            check("m_parity256", m_parity256, exp_q[0].par256);
            check("m_error256", m_error256, exp_q[0].err256);
        end
        check("pkt_cnt32", pkt_cnt32, pkt_n % 4);
        check("err_cnt32", err_cnt32, sat(err32_n, 2));
        check("pkt_cnt1", pkt_cnt1, pkt_n % 16);
        check("err_cnt1", err_cnt1, sat(err1_n, 4));
        check("pkt_cnt256", pkt_cnt256, pkt_n % 16);
        check("err_cnt256", err_cnt256, sat(err256_n, 4));
        @(posedge clk);
        #1;
        if (cons) void'(exp_q.pop_front());
        if (accepted) model_beat();
    endtask

    task automatic send(input logic [255:0] d, input logic last, input logic par);
        logic acc = 1'b0;
        d256 = d; s_last = last; s_par = par; s_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        check("send_accepted", acc, 1'b1);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2;
        check("rst_busy", busy32, 1'b0);
        check("rst_m_valid", m_valid32, 1'b0);
        check("rst_pkt_cnt", pkt_cnt32, 2'd0);
        check("rst_err_cnt", err_cnt256, 4'd0);
        check("rst_s_ready", s_ready32, 1'b1);
        check("rst_m_parity", m_parity32, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0; mode_odd = 1'b0; s_valid = 1'b0; d256 = '0;
        s_last = 1'b0; s_par = 1'b0; m_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Single beat, even mode
        send(256'h7, 1'b1, 1'b1);
        check("t1_m_valid", m_valid32, 1'b1);
        check("t1_m_parity", m_parity32, 1'b1);
        check("t1_m_error", m_error32, 1'b0);
        check("t1_pkt_cnt", pkt_cnt32, 2'd1);
        step(acc);

        // Odd mode 3-beat packet, mode toggled mid-packet
        mode_odd = 1'b1;
        send(256'h1, 1'b0, 1'b0);
        mode_odd = 1'b0;
        send(256'h3, 1'b0, 1'b1);
        send(256'hFFFF_FFFF, 1'b1, 1'b1);
        check("t2_m_parity", m_parity32, 1'b0);
        check("t2_m_error", m_error32, 1'b1);
        check("t2_err_cnt", err_cnt32, 2'd1);
        step(acc);

        // Backpressure, then consume with a simultaneous last beat
        m_ready = 1'b0;
        send(256'h1, 1'b1, 1'b0);
        d256 = 256'h3; s_last = 1'b1; s_par = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("bp_not_accepted", acc, 1'b0);
            check("bp_s_ready", s_ready32, 1'b0);
            check("bp_m_parity", m_parity32, 1'b1);
        end
        m_ready = 1'b1;
        step(acc);
        s_valid = 1'b0;
        check("bp_m_valid_kept", m_valid32, 1'b1);
        check("bp_new_parity", m_parity32, 1'b0);
        check("bp_new_error", m_error32, 1'b1);
        step(acc);

        // Counter saturation and wrap at CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) send(256'h0, 1'b1, 1'b1);
        check("sat_err_cnt", err_cnt32, 2'd3);
        check("wrap_pkt_cnt", pkt_cnt32, 2'd1);
        step(acc);

        // Reset mid-packet
        send(256'h1, 1'b0, 1'b0);
        send(256'h2, 1'b0, 1'b0);
        check("mid_busy", busy32, 1'b1);
        do_reset();
        send(256'h1, 1'b1, 1'b1);
        check("after_rst_parity", m_parity32, 1'b1);
        check("after_rst_pkt_cnt", pkt_cnt32, 2'd1);
        step(acc);

        // Random traffic on all three widths
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) d256[k*32 +: 32] = $urandom;
            s_valid  = ($urandom_range(0, 3) != 0);
            s_last   = ($urandom_range(0, 2) == 0);
            s_par    = $urandom_range(0, 1);
            m_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) mode_odd = ~mode_odd;
            step(acc);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step(acc);
        step(acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
